// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: EX operand forwarding, load-use stall,
// redirect flush sequencing across the 1-cycle-latency instruction memory, and perf counters.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_jump_taken,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  imem_rvalid,
    input  logic                  cnt_clear,
    output logic [1:0]            fwd_rs1_sel,
    output logic [1:0]            fwd_rs2_sel,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            jump_state,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  redirect_events
);

    // alu_data_sel_e
    localparam logic [1:0] SEL_ID2EX_BUF   = 2'd0;
    localparam logic [1:0] SEL_MEM_FORWARD = 2'd1;
    localparam logic [1:0] SEL_WB_FORWARD  = 2'd2;

    // jump_inst_read_delay_e
    localparam logic [1:0] JS_IDLE    = 2'd0;
    localparam logic [1:0] JS_INVALID = 2'd1;
    localparam logic [1:0] JS_WAIT    = 2'd2;

    logic [1:0]           jump_state_q, jump_state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] redir_cnt_q, redir_cnt_d;
    logic                 load_use;
    logic                 mem_hit1, mem_hit2, wb_hit1, wb_hit2;

    assign mem_hit1 = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1);
    assign mem_hit2 = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2);
    assign wb_hit1  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs1);
    assign wb_hit2  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs2);

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        fwd_rs1_sel = SEL_ID2EX_BUF;
        fwd_rs2_sel = SEL_ID2EX_BUF;
        if (mem_hit1)     fwd_rs1_sel = SEL_MEM_FORWARD;
        else if (wb_hit1) fwd_rs1_sel = SEL_WB_FORWARD;
        if (mem_hit2)     fwd_rs2_sel = SEL_MEM_FORWARD;
        else if (wb_hit2) fwd_rs2_sel = SEL_WB_FORWARD;
    end

    // A pending redirect squashes the ID instruction anyway, so a load-use stall would be wasted.
    assign load_use = ex_mem_read && (ex_rd != '0) && !ex_jump_taken && (jump_state_q == JS_IDLE)
                   && ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign pc_stall    = load_use;
    assign if_id_stall = load_use;
    assign id_ex_flush = ex_jump_taken || load_use;
    assign if_id_flush = ex_jump_taken || (jump_state_q == JS_INVALID)
                      || ((jump_state_q == JS_WAIT) && !imem_rvalid);

    always_comb begin
        jump_state_d = jump_state_q;
        if (ex_jump_taken) begin
            jump_state_d = JS_INVALID;
        end else begin
            case (jump_state_q)
                JS_INVALID: jump_state_d = JS_WAIT;
                JS_WAIT:    jump_state_d = imem_rvalid ? JS_IDLE : JS_WAIT;
                default:    jump_state_d = JS_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (cnt_clear) begin
            stall_cnt_d = '0;
            redir_cnt_d = '0;
        end else begin
            if (pc_stall && (stall_cnt_q != '1))      stall_cnt_d = stall_cnt_q + 1'b1;
            if (ex_jump_taken && (redir_cnt_q != '1)) redir_cnt_d = redir_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_state_q <= JS_IDLE;
            stall_cnt_q  <= '0;
            redir_cnt_q  <= '0;
        end else begin
            jump_state_q <= jump_state_d;
            stall_cnt_q  <= stall_cnt_d;
            redir_cnt_q  <= redir_cnt_d;
        end
    end

    assign jump_state      = jump_state_q;
    assign stall_cycles    = stall_cnt_q;
    assign redirect_events = redir_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes reference-model expectations each cycle,
// an independent monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

    localparam int W = 5;
    localparam int CW = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_jump_taken;
    logic mem_reg_write, wb_reg_write, imem_rvalid, cnt_clear;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel, jump_state;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_flush;
    logic [CW-1:0] stall_cycles, redirect_events;

    hazard_ctrl #(.REG_ADDR_W(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_jump_taken(ex_jump_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .imem_rvalid(imem_rvalid), .cnt_clear(cnt_clear),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .pc_stall(pc_stall),
        .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .jump_state(jump_state), .stall_cycles(stall_cycles), .redirect_events(redirect_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int f1, f2, stall, flush_ifid, flush_idex, js, sc, re;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: cycles elapsed since the last redirect (0 = no redirect in flight).
    int m_since_jump = 0;
    int m_stalls = 0;
    int m_redirects = 0;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
        end
    endtask

    function automatic int fwd_of(input int rs);
        if (mem_reg_write && mem_rd != 0 && int'(mem_rd) == rs) return 1;
        if (wb_reg_write && wb_rd != 0 && int'(wb_rd) == rs) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_since_jump = 0;
        m_stalls = 0;
        m_redirects = 0;
    endtask

    // One clock cycle: inputs are already applied by the caller.
    task automatic cycle();
        exp_t e;
        bit hazard, in_flight;
        @(negedge clk);
        if (!rst_n) model_reset();
        #1;
        in_flight = (m_since_jump != 0);
        hazard = ex_mem_read && ex_rd != 0 && !ex_jump_taken && !in_flight &&
                 ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        e.cyc = cyc;
        e.f1 = fwd_of(int'(ex_rs1));
        e.f2 = fwd_of(int'(ex_rs2));
        e.stall = int'(hazard);
        e.flush_idex = int'(ex_jump_taken || hazard);
        e.flush_ifid = int'(ex_jump_taken || m_since_jump == 1 || (m_since_jump >= 2 && !imem_rvalid));
        e.js = (m_since_jump == 0) ? 0 : (m_since_jump == 1 ? 1 : 2);
        e.sc = m_stalls;
        e.re = m_redirects;
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (cnt_clear) begin
                m_stalls = 0;
                m_redirects = 0;
            end else begin
                if (hazard) m_stalls = (m_stalls == CNT_MAX) ? CNT_MAX : m_stalls + 1;
                if (ex_jump_taken) m_redirects = (m_redirects == CNT_MAX) ? CNT_MAX : m_redirects + 1;
            end
            if (ex_jump_taken) m_since_jump = 1;
            else if (m_since_jump == 1) m_since_jump = 2;
            else if (m_since_jump >= 2 && imem_rvalid) m_since_jump = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic zero_inputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_jump_taken} = '0;
        {mem_reg_write, wb_reg_write, imem_rvalid, cnt_clear} = '0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1;
        ex_rd = 5'd7;
        id_rs2 = 5'd7;
        id_uses_rs2 = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("fwd_rs1_sel", int'(fwd_rs1_sel), e.f1);
                check("fwd_rs2_sel", int'(fwd_rs2_sel), e.f2);
                check("pc_stall", int'(pc_stall), e.stall);
                check("if_id_stall", int'(if_id_stall), e.stall);
                check("if_id_flush", int'(if_id_flush), e.flush_ifid);
                check("id_ex_flush", int'(id_ex_flush), e.flush_idex);
                check("jump_state", int'(jump_state), e.js);
                check("stall_cycles", int'(stall_cycles), e.sc);
                check("redirect_events", int'(redirect_events), e.re);
            end
        end
    end

    initial begin
        int budget;
        zero_inputs();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Forwarding priority and x0 exclusion
        ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
        cycle();
        mem_reg_write = 1'b0;
        cycle();
        ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b1;
        cycle();
        zero_inputs();
        ex_rs2 = 5'd9; wb_rd = 5'd9; wb_reg_write = 1'b1; mem_rd = 5'd3; mem_reg_write = 1'b1;
        cycle();

        // Load-use, then the same without the rs2 read
        zero_inputs(); set_load_use();
        cycle();
        zero_inputs();
        cycle();
        set_load_use(); id_uses_rs2 = 1'b0;
        cycle();

        // Jump with fast fetch
        zero_inputs(); ex_jump_taken = 1'b1;
        cycle();
        ex_jump_taken = 1'b0;
        cycle();
        imem_rvalid = 1'b1;
        cycle();
        cycle();

        // Jump with slow fetch (three WAIT cycles)
        zero_inputs(); ex_jump_taken = 1'b1;
        cycle();
        ex_jump_taken = 1'b0;
        repeat (4) cycle();
        imem_rvalid = 1'b1;
        cycle();
        cycle();

        // Jump coincident with load-use, then second jump while waiting
        zero_inputs(); set_load_use(); ex_jump_taken = 1'b1;
        cycle();
        zero_inputs(); set_load_use();
        repeat (2) cycle();
        ex_jump_taken = 1'b1;
        cycle();
        ex_jump_taken = 1'b0;
        repeat (3) cycle();
        imem_rvalid = 1'b1;
        cycle();

        // Counter saturation and clear
        zero_inputs(); set_load_use();
        repeat (CNT_MAX + 5) cycle();
        check("stall_sat", int'(stall_cycles), CNT_MAX);
        cnt_clear = 1'b1;
        cycle();
        cnt_clear = 1'b0;
        zero_inputs();
        cycle();
        check("stall_cleared", int'(stall_cycles), 0);

        // Asynchronous reset while waiting for the target fetch
        ex_jump_taken = 1'b1;
        cycle();
        ex_jump_taken = 1'b0;
        repeat (2) cycle();
        check("pre_rst_wait", int'(jump_state), 2);
        rst_n = 1'b0;
        #1;
        check("async_rst_state", int'(jump_state), 0);
        check("async_rst_redirects", int'(redirect_events), 0);
        cycle();
        rst_n = 1'b1;
        cycle();

        // Randomized traffic on a small register window to provoke matches
        repeat (3000) begin
            id_rs1 = W'($urandom_range(0, 3));
            id_rs2 = W'($urandom_range(0, 3));
            ex_rs1 = W'($urandom_range(0, 3));
            ex_rs2 = W'($urandom_range(0, 3));
            ex_rd = W'($urandom_range(0, 3));
            mem_rd = W'($urandom_range(0, 3));
            wb_rd = W'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1));
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            mem_reg_write = 1'($urandom_range(0, 1));
            wb_reg_write = 1'($urandom_range(0, 1));
            ex_jump_taken = ($urandom_range(0, 7) == 0);
            imem_rvalid = ($urandom_range(0, 2) != 0);
            cnt_clear = ($urandom_range(0, 63) == 0);
            cycle();
        end

        zero_inputs();
        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32I core. It selects the EX-stage operand forwarding paths and detects load-use hazards, inserting a stall and bubble when one occurs. It sequences the IF/ID and ID/EX flushes after a taken branch or jump, using the jump instruction-read-delay FSM (IDLE/INVALID/WAIT) to cover the 1-cycle-latency instruction memory. It also keeps saturating counters of stall cycles and redirect events.

Parameters:
REG_ADDR_W, 5, register-index width
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
id_rs1  input  REG_ADDR_W  rs1 index of the instruction in ID
id_rs2  input  REG_ADDR_W  rs2 index of the instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_rs1  input  REG_ADDR_W  rs1 index in EX
ex_rs2  input  REG_ADDR_W  rs2 index in EX
ex_rd  input  REG_ADDR_W  rd index in EX
ex_mem_read  input  1  EX instruction is a LOAD
ex_jump_taken  input  1  branch taken, or JAL/JALR resolved in EX
mem_rd  input  REG_ADDR_W  rd index in MEM
mem_reg_write  input  1  MEM instruction writes rd
wb_rd  input  REG_ADDR_W  rd index in WB
wb_reg_write  input  1  WB instruction writes rd
imem_rvalid  input  1  instruction-memory read data valid this cycle
cnt_clear  input  1  synchronous clear of both counters
fwd_rs1_sel  output  2  alu_data_sel_e for ALU operand rs1
fwd_rs2_sel  output  2  alu_data_sel_e for ALU operand rs2
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID register
if_id_flush  output  1  load a bubble into IF/ID
id_ex_flush  output  1  load a bubble into ID/EX
jump_state  output  2  current jump_inst_read_delay_e state
stall_cycles  output  CNT_WIDTH  count of cycles with pc_stall=1
redirect_events  output  CNT_WIDTH  count of cycles with ex_jump_taken=1

Behaviour:
- Reset (rst_n=0, asynchronous):
  - jump_state=IDLE.
  - Both counters = 0.
  - Combinational outputs follow the rules below. With all inputs 0, every output is 0 and both forwarding selects are id2ex_buf.
- Forwarding (combinational, evaluated separately for rs1 and rs2, priority in this order):
  - If mem_reg_write && mem_rd!=0 && mem_rd==ex_rsX, select mem_forward.
  - Else if wb_reg_write && wb_rd!=0 && wb_rd==ex_rsX, select wb_forward.
  - Else select id2ex_buf.
  - When MEM and WB both match, MEM wins.
- Load-use (combinational): load_use = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
  - Load-use is masked to 0 when ex_jump_taken=1 or jump_state!=IDLE.
  - When load_use=1: pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble), for exactly one cycle per hazard.
- Jump FSM (jump_inst_read_delay_e):
  - IDLE: ex_jump_taken=1 sets if_id_flush=1 and id_ex_flush=1 that cycle; next state INVALID.
  - INVALID: the wrong-path fetch data is returning. if_id_flush=1. Next state WAIT.
  - WAIT: if_id_flush = ~imem_rvalid. When imem_rvalid=1, the target instruction is accepted and next state is IDLE. Otherwise stay in WAIT indefinitely (no timeout).
  - ex_jump_taken=1 in INVALID or WAIT: treated as a new redirect. Assert both flushes that cycle; next state INVALID.
- Stall/flush interaction: flush has priority over stall. pc_stall and if_id_stall are never asserted in the same cycle as if_id_flush.
- Counters:
  - stall_cycles increments each cycle pc_stall=1.
  - redirect_events increments each cycle ex_jump_taken=1.
  - Both saturate at all-ones.
  - cnt_clear=1 forces both counters to 0 next edge; clear wins over increment.
- Reset asserted mid-sequence (e.g. in WAIT) returns the FSM to IDLE immediately and clears the counters.

Test Plan:
- Forwarding: ex_rs1=5; mem_rd=5, mem_reg_write=1; wb_rd=5, wb_reg_write=1 -> fwd_rs1_sel=mem_forward. Drop mem_reg_write -> wb_forward. Set ex_rs1=0 with matching rd=0 -> id2ex_buf.
- Load-use: ex_mem_read=1, ex_rd=7, id_rs2=7, id_uses_rs2=1 -> one cycle of pc_stall=if_id_stall=id_ex_flush=1; stall_cycles 0->1. Repeat with id_uses_rs2=0 -> no stall.
- Jump with immediate fetch: ex_jump_taken pulse, imem_rvalid=1 from cycle +2 -> states IDLE,INVALID,WAIT,IDLE; if_id_flush=1,1,0; redirect_events=1.
- Slow imem: jump, then imem_rvalid low for 3 WAIT cycles -> if_id_flush held 4 cycles total after the jump cycle; return to IDLE on rvalid.
- Jump+load-use in the same cycle -> flushes only, pc_stall=0, stall_cycles unchanged. Second jump while in WAIT -> state INVALID.
- Saturation/clear: force 65536 stall cycles -> stall_cycles=16'hFFFF holds. cnt_clear together with a stall -> 0. rst_n low in WAIT -> jump_state=IDLE asynchronously.
